// File: rtl/sequential_divider.sv
// sequential_divider: unsigned restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. Results and flags
// are registered and held with done_out until the next accepted start.
//
//   state | meaning
//   IDLE  | no result since reset, waiting for start_in
//   CALC  | shift/subtract iterations, or one cycle to report an exception
//   DONE  | result valid on outputs, start_in launches the next division
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic [2*WIDTH-1:0]   dividend_in,
  input  logic [WIDTH-1:0]     divisor_in,
  output logic [WIDTH-1:0]     quotient_out,
  output logic [WIDTH-1:0]     remainder_out,
  output logic                 done_out,
  output logic                 overflow_out,
  output logic                 div_by_zero_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  // Partial remainder is kept in WIDTH bits: it is always below the divisor
  // between steps, so only the shifted value needs the extra top bit.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             exc_zero_q;
  logic             exc_ovf_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [CW-1:0]    cnt_d;
  logic             last_step;
  logic             start_zero;
  logic             start_ovf;

  // One restoring step: shift {R,Q} left, subtract divisor when it fits.
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    quo_sh    = {quo_q[WIDTH-2:0], 1'b0};
    fits      = (rem_sh >= {1'b0, div_q});
    rem_d     = fits ? WIDTH'(rem_sh - {1'b0, div_q}) : rem_sh[WIDTH-1:0];
    quo_d     = {quo_sh[WIDTH-1:1], fits};
    cnt_d     = cnt_q - 1'b1;
    last_step = (cnt_q == CW'(1));
  end

  // Exception classification of the operands presented with start_in.
  always_comb begin
    start_zero = (divisor_in == '0);
    start_ovf  = !start_zero && (dividend_in[2*WIDTH-1:WIDTH] >= divisor_in);
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q         <= IDLE;
      rem_q           <= '0;
      quo_q           <= '0;
      div_q           <= '0;
      cnt_q           <= '0;
      exc_zero_q      <= 1'b0;
      exc_ovf_q       <= 1'b0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      done_out        <= 1'b0;
      overflow_out    <= 1'b0;
      div_by_zero_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_in) begin
            done_out        <= 1'b0;
            overflow_out    <= 1'b0;
            div_by_zero_out <= 1'b0;
            div_q           <= divisor_in;
            exc_zero_q      <= start_zero;
            exc_ovf_q       <= start_ovf;
            rem_q           <= dividend_in[2*WIDTH-1:WIDTH];
            quo_q           <= dividend_in[WIDTH-1:0];
            cnt_q           <= (start_zero || start_ovf) ? CW'(1) : CW'(WIDTH);
            state_q         <= CALC;
          end
        end
        CALC: begin
          if (exc_zero_q || exc_ovf_q) begin
            // Exceptions finish one edge after acceptance with a saturated quotient.
            quotient_out    <= '1;
            remainder_out   <= '0;
            overflow_out    <= exc_ovf_q;
            div_by_zero_out <= exc_zero_q;
            done_out        <= 1'b1;
            exc_zero_q      <= 1'b0;
            exc_ovf_q       <= 1'b0;
            cnt_q           <= '0;
            state_q         <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            if (last_step) begin
              quotient_out  <= quo_d;
              remainder_out <= rem_d;
              done_out      <= 1'b1;
              state_q       <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Unsigned restoring divider producing one quotient bit per clock, the inverse operation of the team's sequential multiplicator. It divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and uses the same start_in / done_out handshake, so a product from the multiplicator can be fed back as a dividend for round-trip checking. It sits beside the multiplicator in the arithmetic datapath and is driven by a controller or testbench interface.

## Interface
- WIDTH, 8: divisor, quotient and remainder width; dividend is 2*WIDTH.
- clock  input  1  rising-edge clock.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  level-sampled at a rising edge while not busy; begins a division.
- dividend_in  input  2*WIDTH  unsigned dividend, sampled with start_in.
- divisor_in  input  WIDTH  unsigned divisor, sampled with start_in.
- quotient_out  output  WIDTH  quotient (registered).
- remainder_out  output  WIDTH  remainder (registered).
- done_out  output  1  high while result is valid; held until next accepted start or reset.
- overflow_out  output  1  quotient does not fit WIDTH bits (dividend[2W-1:W] >= divisor, divisor nonzero).
- div_by_zero_out  output  1  divisor was zero.

## Operation
- States: IDLE, CALC, DONE.
- Reset (any state): state=IDLE, all outputs 0, counter 0, working registers 0.
- IDLE/DONE + start_in=1 at edge E0: latch operands, clear done_out/overflow_out/div_by_zero_out; then:
  - divisor=0 -> DONE at edge E0+1: div_by_zero_out=1, quotient_out=all ones, remainder_out=0.
  - dividend high half >= divisor -> DONE at E0+1: overflow_out=1, quotient_out=all ones, remainder_out=0.
  - else -> CALC, R (WIDTH+1 bits) = dividend high half, Q = dividend low half, counter=WIDTH.
- CALC, each edge: {R,Q} <<= 1; if R >= divisor then R -= divisor, Q[0]=1; counter--. On the step where counter reaches 0: quotient_out=Q, remainder_out=R[WIDTH-1:0], done_out=1, state=DONE.
- CALC: start_in ignored; operand inputs ignored after E0.
- DONE: outputs hold; start_in=1 re-enters as above (back-to-back allowed, done_out drops at that edge).
- quotient_out/remainder_out keep previous result during CALC; only updated at completion.
- Invariant on normal completion: quotient*divisor + remainder = dividend, remainder < divisor.

## Timing
- Normal latency: done_out rises at edge E0+WIDTH (8 cycles for WIDTH=8), all result outputs valid same edge.
- Exception latency: done_out rises at E0+1 with its flag.
- done_out is a level, not a pulse; it rises exactly once per accepted start.
- start_in must be high across a rising edge to be accepted; a start pulse not spanning an edge is lost.
- Reset asserted mid-CALC aborts immediately (asynchronously); no done_out follows; first start after deassertion behaves normally.
- Start and reset simultaneously: reset wins.
- Overflow and divide-by-zero flags are mutually exclusive; both cleared on next accepted start.

## Test plan
- WIDTH=8, dividend 1000, divisor 7, start one edge -> done_out after 8 edges, quotient 142, remainder 6, flags 0.
- Dividend 65279, divisor 255 -> quotient 255, remainder 254 (max-quotient boundary); dividend 65535, divisor 255 -> overflow_out=1 after 1 edge, quotient 255, remainder 0.
- Dividend 100, divisor 0 -> div_by_zero_out=1 at E0+1, overflow_out=0, quotient 255, remainder 0; dividend 0, divisor 5 -> quotient 0, remainder 0 after 8 edges.
- Reset asserted at cycle 4 of 1000/7 -> all outputs 0 immediately, done_out stays 0; then 510/255 -> quotient 2, remainder 0.
- start_in held high throughout CALC and re-asserted in DONE: mid-run start ignored (result 1000/7 unchanged); start in DONE launches 200/3 -> done_out falls that edge, rises 8 edges later with quotient 66, remainder 2.
- Randomized round trip: multiplicator product of a,b (b nonzero) divided by b -> quotient a, remainder 0, no flags.
